// File: rtl/btb_set_assoc.sv
// btb_set_assoc: set-associative Branch Target Buffer for the fetch stage.
//
// Each set holds WAYS entries. Every entry has a valid bit, a tag, a target
// and a 2-bit direction counter. Replacement within a set is round-robin.
// After reset, a sweep clears the valid bits one set per cycle.
//
// Ports:
//   clk             clock
//   rst             synchronous active-low reset
//   pc              fetch PC to look up
//   stall           holds the registered lookup result
//   btbHit          registered lookup hit
//   btbPredictedPc  registered predicted target (0 on miss)
//   btbTaken        registered direction prediction (0 on miss)
//   initBusy        invalidation sweep in progress
//   updValid        resolved-branch update strobe
//   updPc           PC of the resolved branch
//   updTarget       resolved target
//   updTaken        resolved direction
module btb_set_assoc #(
    parameter int PC_WIDTH = 32,
    parameter int SETS     = 64,
    parameter int WAYS     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                stall,
    output logic                btbHit,
    output logic [PC_WIDTH-1:0] btbPredictedPc,
    output logic                btbTaken,
    output logic                initBusy,
    input  logic                updValid,
    input  logic [PC_WIDTH-1:0] updPc,
    input  logic [PC_WIDTH-1:0] updTarget,
    input  logic                updTaken
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;
    // A 1-way configuration still needs a legal 1-bit way index.
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    // Storage
    logic [WAYS-1:0]     valid_q  [SETS];
    logic [RR_W-1:0]     rr_q     [SETS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [PC_WIDTH-1:0] target_q [SETS][WAYS];
    logic [1:0]          ctr_q    [SETS][WAYS];

    // Control and registered outputs
    state_e              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic                busy_q;
    logic                hit_q;
    logic [PC_WIDTH-1:0] pred_q;
    logic                taken_q;

    // Lookup next-state values
    logic [IDX_W-1:0]    lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic                hit_d;
    logic [PC_WIDTH-1:0] pred_d;
    logic                taken_d;

    // Update decode
    logic [IDX_W-1:0]    up_idx_s;
    logic [TAG_W-1:0]    up_tag_s;
    logic [WAYS-1:0]     up_match_s;
    logic                up_hit_s;
    logic [RR_W-1:0]     up_way_s;
    logic [RR_W-1:0]     inv_way_s;
    logic                any_inv_s;
    logic [RR_W-1:0]     wr_way_s;
    logic [RR_W-1:0]     rr_next_s;
    logic                do_upd_s;
    logic                alloc_s;
    logic                rr_adv_s;

    // The two byte-offset bits of each PC never take part in indexing.
    logic unused_s;
    assign unused_s = ^{pc[1:0], updPc[1:0]};

    assign btbHit         = hit_q;
    assign btbPredictedPc = pred_q;
    assign btbTaken       = taken_q;
    assign initBusy       = busy_q;

    // Lookup: tag compare across the ways of the set addressed by pc.
    always_comb begin
        lk_idx_s = pc[IDX_W+1:2];
        lk_tag_s = pc[PC_WIDTH-1:IDX_W+2];
        hit_d    = 1'b0;
        pred_d   = '0;
        taken_d  = 1'b0;
        // At most one way matches, so an AND-OR mux selects its fields.
        for (int w = 0; w < WAYS; w++) begin
            hit_d   = hit_d | (valid_q[lk_idx_s][w] & (tag_q[lk_idx_s][w] == lk_tag_s));
            pred_d  = pred_d | ((valid_q[lk_idx_s][w] & (tag_q[lk_idx_s][w] == lk_tag_s))
                                ? target_q[lk_idx_s][w] : {PC_WIDTH{1'b0}});
            taken_d = taken_d | (valid_q[lk_idx_s][w] & (tag_q[lk_idx_s][w] == lk_tag_s)
                                 & ctr_q[lk_idx_s][w][1]);
        end
    end

    // Update decode: hit way, lowest invalid way and victim selection.
    always_comb begin
        up_idx_s   = updPc[IDX_W+1:2];
        up_tag_s   = updPc[PC_WIDTH-1:IDX_W+2];
        up_match_s = '0;
        up_way_s   = '0;
        inv_way_s  = '0;
        for (int w = 0; w < WAYS; w++) begin
            up_match_s[w] = valid_q[up_idx_s][w] & (tag_q[up_idx_s][w] == up_tag_s);
            up_way_s      = up_way_s | (up_match_s[w] ? RR_W'(w) : {RR_W{1'b0}});
        end
        // Walking downwards leaves the lowest-index invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            inv_way_s = valid_q[up_idx_s][w] ? inv_way_s : RR_W'(w);
        end
        up_hit_s  = |up_match_s;
        any_inv_s = ~(&valid_q[up_idx_s]);
        rr_next_s = (rr_q[up_idx_s] == RR_W'(WAYS - 1)) ? {RR_W{1'b0}}
                                                        : rr_q[up_idx_s] + RR_W'(1);
        wr_way_s  = up_hit_s ? up_way_s : (any_inv_s ? inv_way_s : rr_q[up_idx_s]);
        do_upd_s  = (state_q == ST_READY) & updValid & (up_hit_s | updTaken);
        alloc_s   = do_upd_s & ~up_hit_s;
        rr_adv_s  = alloc_s & ~any_inv_s;
    end

    // Controller: reset, invalidation sweep, lookup result registers, valid/rr state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            hit_q   <= 1'b0;
            pred_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    valid_q[ptr_q] <= '0;
                    rr_q[ptr_q]    <= '0;
                    hit_q          <= 1'b0;
                    pred_q         <= '0;
                    taken_q        <= 1'b0;
                    if (ptr_q == IDX_W'(SETS - 1)) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + IDX_W'(1);
                    end
                end
                ST_READY: begin
                    // Result registers read the arrays before this edge's update.
                    if (!stall) begin
                        hit_q   <= hit_d;
                        pred_q  <= pred_d;
                        taken_q <= taken_d;
                    end
                    if (alloc_s) begin
                        valid_q[up_idx_s][wr_way_s] <= 1'b1;
                    end
                    if (rr_adv_s) begin
                        rr_q[up_idx_s] <= rr_next_s;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                    hit_q   <= 1'b0;
                    pred_q  <= '0;
                    taken_q <= 1'b0;
                end
            endcase
        end
    end

    // Entry payload: tag, target and counter need no reset; valid gates them.
    always_ff @(posedge clk) begin
        if (rst && do_upd_s) begin
            target_q[up_idx_s][wr_way_s] <= updTarget;
            ctr_q[up_idx_s][wr_way_s]    <= up_hit_s
                                            ? ctr_next(ctr_q[up_idx_s][wr_way_s], updTaken)
                                            : 2'b10;
            if (alloc_s) begin
                tag_q[up_idx_s][wr_way_s] <= up_tag_s;
            end
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
module tb_btb_set_assoc;

    localparam int PW    = 32;
    localparam int SETS  = 64;
    localparam int WAYS  = 2;
    localparam int IDX_W = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] pc = '0;
    logic          stall = 1'b0;
    logic          btbHit;
    logic [PW-1:0] btbPredictedPc;
    logic          btbTaken;
    logic          initBusy;
    logic          updValid = 1'b0;
    logic [PW-1:0] updPc = '0;
    logic [PW-1:0] updTarget = '0;
    logic          updTaken = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-set list of WAYS entries, plain integers.
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    int          m_rr    [SETS];
    int          busy_cnt = SETS;
    bit          e_hit, e_tk, e_busy;
    logic [31:0] e_pc;

    always #5 clk = ~clk;

    btb_set_assoc #(.PC_WIDTH(PW), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .btbHit(btbHit), .btbPredictedPc(btbPredictedPc), .btbTaken(btbTaken),
        .initBusy(initBusy), .updValid(updValid), .updPc(updPc),
        .updTarget(updTarget), .updTaken(updTaken)
    );

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + IDX_W);
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic mdl_edge();
        int s, hw, vic;
        logic [31:0] t;
        if (!rst) begin
            busy_cnt = SETS;
            e_busy = 1'b1; e_hit = 1'b0; e_pc = '0; e_tk = 1'b0;
            for (int i = 0; i < SETS; i++) begin
                m_rr[i] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[i][w] = 1'b0;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            e_busy = (busy_cnt > 0);
            e_hit = 1'b0; e_pc = '0; e_tk = 1'b0;
        end else begin
            if (!stall) begin
                s = set_of(pc); t = tag_of(pc);
                e_hit = 1'b0; e_pc = '0; e_tk = 1'b0;
                for (int w = 0; w < WAYS; w++)
                    if (m_valid[s][w] && m_tag[s][w] == t) begin
                        e_hit = 1'b1; e_pc = m_tgt[s][w]; e_tk = (m_ctr[s][w] >= 2);
                    end
            end
            if (updValid) begin
                s = set_of(updPc); t = tag_of(updPc); hw = -1;
                for (int w = 0; w < WAYS; w++)
                    if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
                if (hw >= 0) begin
                    m_tgt[s][hw] = updTarget;
                    m_ctr[s][hw] = updTaken ? ((m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1)
                                            : ((m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1);
                end else if (updTaken) begin
                    vic = -1;
                    for (int w = 0; w < WAYS; w++)
                        if (!m_valid[s][w] && vic < 0) vic = w;
                    if (vic < 0) begin
                        vic = m_rr[s];
                        m_rr[s] = (m_rr[s] + 1) % WAYS;
                    end
                    m_valid[s][vic] = 1'b1; m_tag[s][vic] = t;
                    m_tgt[s][vic] = updTarget; m_ctr[s][vic] = 2;
                end
            end
        end
    endtask

    task automatic step();
        mdl_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic st, input logic uv,
                         input logic [31:0] up, input logic [31:0] ut, input logic utk);
        pc = p; stall = st; updValid = uv; updPc = up; updTarget = ut; updTaken = utk;
    endtask

    task automatic do_reset();
        drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (SETS) step();
    endtask

    task automatic test_reset();
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        step();
        checks++;
        if (btbHit !== 1'b0 || btbPredictedPc !== 32'h0 || btbTaken !== 1'b0 || initBusy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got hit=%b pc=%h tk=%b busy=%b want 0 0 0 1",
                     btbHit, btbPredictedPc, btbTaken, initBusy);
        end
        rst = 1'b1;
        // An update attempted while sweeping must be dropped.
        drive(32'h100, 1'b0, 1'b1, 32'h100, 32'h999, 1'b1);
        for (int i = 1; i <= SETS; i++) begin
            step();
            checks++;
            if (initBusy !== (i < SETS) || btbHit !== 1'b0) begin
                failures++;
                $display("FAIL init_sweep cycle=%0d got busy=%b hit=%b want busy=%b hit=0",
                         i, initBusy, btbHit, (i < SETS));
            end
        end
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (btbHit !== 1'b0 || e_hit !== 1'b0) begin
            failures++;
            $display("FAIL init_upd_ignored got hit=%b want 0", btbHit);
        end
    endtask

    task automatic test_alloc();
        drive(32'h40, 1'b0, 1'b1, 32'h100, 32'h200, 1'b1);
        step();
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPc !== 32'h200 || btbTaken !== 1'b1) begin
            failures++;
            $display("FAIL alloc_hit got hit=%b pc=%h tk=%b want 1 00000200 1",
                     btbHit, btbPredictedPc, btbTaken);
        end
    endtask

    task automatic test_counter();
        bit dirs [6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit exp_tk [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(32'h100, 1'b0, 1'b1, 32'h100, 32'h200, dirs[i]);
            step();
            drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            step();
            checks++;
            if (btbHit !== 1'b1 || btbTaken !== exp_tk[i] || btbPredictedPc !== 32'h200) begin
                failures++;
                $display("FAIL counter step=%0d got hit=%b tk=%b pc=%h want 1 %b 00000200",
                         i, btbHit, btbTaken, btbPredictedPc, exp_tk[i]);
            end
        end
    endtask

    task automatic test_evict();
        logic [31:0] lk_pc  [3] = '{32'h100, 32'h200, 32'h300};
        logic [31:0] tgt    [3] = '{32'h1100, 32'h1200, 32'h1300};
        bit          exp_h  [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] exp_p  [3] = '{32'h0, 32'h1200, 32'h1300};
        do_reset();
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears got hit=%b want 0", btbHit);
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'h40, 1'b0, 1'b1, lk_pc[i], tgt[i], 1'b1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(lk_pc[i], 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            step();
            checks++;
            if (btbHit !== exp_h[i] || btbPredictedPc !== exp_p[i]) begin
                failures++;
                $display("FAIL evict pc=%h got hit=%b tgt=%h want %b %h",
                         lk_pc[i], btbHit, btbPredictedPc, exp_h[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(32'h40, 1'b0, 1'b1, 32'h100, 32'h200, 1'b1);
        step();
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPc !== 32'h200) begin
            failures++;
            $display("FAIL stall_pre got hit=%b pc=%h want 1 00000200", btbHit, btbPredictedPc);
        end
        drive(32'h400, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (btbHit !== 1'b1 || btbPredictedPc !== 32'h200 || btbTaken !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got hit=%b pc=%h tk=%b want 1 00000200 1",
                         i, btbHit, btbPredictedPc, btbTaken);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (btbHit !== 1'b0 || btbPredictedPc !== 32'h0 || btbTaken !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got hit=%b pc=%h tk=%b want 0 0 0",
                     btbHit, btbPredictedPc, btbTaken);
        end
    endtask

    task automatic test_collision();
        drive(32'h500, 1'b0, 1'b1, 32'h500, 32'h5A0, 1'b1);
        step();
        checks++;
        if (btbHit !== 1'b0) begin
            failures++;
            $display("FAIL collision_same got hit=%b want 0", btbHit);
        end
        drive(32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (btbHit !== 1'b1 || btbPredictedPc !== 32'h5A0 || btbTaken !== 1'b1) begin
            failures++;
            $display("FAIL collision_next got hit=%b pc=%h tk=%b want 1 000005a0 1",
                     btbHit, btbPredictedPc, btbTaken);
        end
    endtask

    // Random traffic on a few sets and tags so hits, conflicts and evictions recur.
    task automatic test_random();
        logic [31:0] p, u;
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 4) << 8) | ($urandom_range(0, 1) << 2);
            u = ($urandom_range(0, 4) << 8) | ($urandom_range(0, 1) << 2);
            rst = ($urandom_range(0, 249) != 0);
            drive(p, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), u,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
            step();
            checks++;
            if (btbHit !== e_hit || btbPredictedPc !== e_pc || btbTaken !== e_tk ||
                initBusy !== e_busy) begin
                failures++;
                $display("FAIL random cycle=%0d got hit=%b pc=%h tk=%b busy=%b want %b %h %b %b",
                         i, btbHit, btbPredictedPc, btbTaken, initBusy, e_hit, e_pc, e_tk, e_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_evict();
        test_stall();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
